// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM encoding and
// the fixed results returned by the compare opcodes.
package alu_pkg;

  localparam int unsigned FUN_W = 4;

  localparam logic [FUN_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [FUN_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [FUN_W-1:0] ALU_MUL  = 4'b0010;
  localparam logic [FUN_W-1:0] ALU_DIV  = 4'b0011;
  localparam logic [FUN_W-1:0] ALU_AND  = 4'b0100;
  localparam logic [FUN_W-1:0] ALU_OR   = 4'b0101;
  localparam logic [FUN_W-1:0] ALU_NAND = 4'b0110;
  localparam logic [FUN_W-1:0] ALU_NOR  = 4'b0111;
  localparam logic [FUN_W-1:0] ALU_XOR  = 4'b1000;
  localparam logic [FUN_W-1:0] ALU_XNOR = 4'b1001;
  localparam logic [FUN_W-1:0] ALU_EQ   = 4'b1010;
  localparam logic [FUN_W-1:0] ALU_GT   = 4'b1011;
  localparam logic [FUN_W-1:0] ALU_LT   = 4'b1100;
  localparam logic [FUN_W-1:0] ALU_SHR  = 4'b1101;
  localparam logic [FUN_W-1:0] ALU_SHL  = 4'b1110;
  localparam logic [FUN_W-1:0] ALU_ILL  = 4'b1111;

  localparam int unsigned CMP_EQ_RES = 1;
  localparam int unsigned CMP_GT_RES = 2;
  localparam int unsigned CMP_LT_RES = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_seq_div.sv
// Iterative restoring divider, one quotient bit per clock, MSB first.
// Ports:
//   CLK, RST           clock, synchronous active-low reset (aborts a division)
//   start              load dividend/divisor and arm the OPER_WIDTH-step counter
//   dividend, divisor  unsigned operands (divisor must be non-zero)
//   quotient_c         quotient after the current step (combinational)
//   remainder_c        remainder after the current step (combinational)
//   done_c             high during the final step; quotient_c/remainder_c are final
module alu_seq_div #(
  parameter int unsigned OPER_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [OPER_WIDTH-1:0] dividend,
  input  logic [OPER_WIDTH-1:0] divisor,
  output logic [OPER_WIDTH-1:0] quotient_c,
  output logic [OPER_WIDTH-1:0] remainder_c,
  output logic                  done_c
);

  localparam int unsigned W     = OPER_WIDTH;
  localparam int unsigned CNT_W = $clog2(OPER_WIDTH + 1);

  logic [W-1:0]     rem_q;
  logic [W-1:0]     quo_q;
  logic [W-1:0]     dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W:0]       partial_c;
  logic             ge_c;

  // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    partial_c   = {rem_q, quo_q[W-1]};
    ge_c        = (partial_c >= {1'b0, dvs_q});
    remainder_c = W'(ge_c ? (partial_c - {1'b0, dvs_q}) : partial_c);
    quotient_c  = {quo_q[W-2:0], ge_c};
    done_c      = (cnt_q == CNT_W'(1));
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CNT_W'(W);
    end else if (cnt_q != '0) begin
      rem_q <= remainder_c;
      quo_q <= quotient_c;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_pipe.sv
// Registered ALU with carry/zero/error flags and an optional multi-cycle
// divider guarded by ALU_DIV_EN (undefined: DIV is an illegal opcode, BUSY=0).
// Ports:
//   CLK, RST    clock, synchronous active-low reset
//   A, B        unsigned operands
//   EN          issue strobe, accepted when BUSY is low
//   ALU_FUN     opcode (see alu_pkg)
//   ALU_OUT     registered result, held until the next result
//   OUT_VALID   one-cycle pulse with each new ALU_OUT
//   BUSY        high while a division iterates
//   CARRY       ADD carry / SUB borrow; ZERO result==0; ERR div-by-zero/illegal
module alu_seq_pipe
  import alu_pkg::*;
#(
  parameter int unsigned OPER_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 2 * OPER_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [OPER_WIDTH-1:0] A,
  input  logic [OPER_WIDTH-1:0] B,
  input  logic                  EN,
  input  logic [FUN_W-1:0]      ALU_FUN,
  output logic [OUT_WIDTH-1:0]  ALU_OUT,
  output logic                  OUT_VALID,
  output logic                  BUSY,
  output logic                  CARRY,
  output logic                  ZERO,
  output logic                  ERR
);

  localparam int unsigned W  = OPER_WIDTH;
  localparam int unsigned OW = OUT_WIDTH;

  alu_state_e state, state_nxt;
  logic          load_c;
  logic [OW-1:0] res_c;
  logic          carry_c;
  logic          err_c;
  logic [W:0]    sum_c;
  logic [W-1:0]  lg_c;

`ifdef ALU_DIV_EN
  logic          start_c;
  logic          div_done_c;
  logic [W-1:0]  div_quo_c;
  logic [W-1:0]  div_rem_c;

  alu_seq_div #(
    .OPER_WIDTH (W)
  ) u_div (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start_c),
    .dividend    (A),
    .divisor     (B),
    .quotient_c  (div_quo_c),
    .remainder_c (div_rem_c),
    .done_c      (div_done_c)
  );
`endif

  assign sum_c = {1'b0, A} + {1'b0, B};

  // Next-state and result selection; issue is only possible in IDLE (BUSY low)
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    res_c     = '0;
    carry_c   = 1'b0;
    err_c     = 1'b0;
    lg_c      = '0;
`ifdef ALU_DIV_EN
    start_c   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (EN) begin
          load_c = 1'b1;
          case (ALU_FUN)
            ALU_ADD: begin
              res_c   = OW'(sum_c);
              carry_c = sum_c[W];
            end
            ALU_SUB: begin
              res_c   = OW'(A) - OW'(B);
              carry_c = (A < B);
            end
            ALU_MUL:  res_c = OW'(A) * OW'(B);
            ALU_DIV: begin
`ifdef ALU_DIV_EN
              if (B == '0) begin
                // Divide-by-zero: saturated quotient, dividend returned as remainder
                res_c = OW'({A, {W{1'b1}}});
                err_c = 1'b1;
              end else begin
                load_c    = 1'b0;
                start_c   = 1'b1;
                state_nxt = ST_DIV;
              end
`else
              err_c = 1'b1;
`endif
            end
            ALU_AND:  begin lg_c = A & B;    res_c = OW'(lg_c); end
            ALU_OR:   begin lg_c = A | B;    res_c = OW'(lg_c); end
            ALU_NAND: begin lg_c = ~(A & B); res_c = OW'(lg_c); end
            ALU_NOR:  begin lg_c = ~(A | B); res_c = OW'(lg_c); end
            ALU_XOR:  begin lg_c = A ^ B;    res_c = OW'(lg_c); end
            ALU_XNOR: begin lg_c = ~(A ^ B); res_c = OW'(lg_c); end
            ALU_EQ:   res_c = (A == B) ? OW'(CMP_EQ_RES) : '0;
            ALU_GT:   res_c = (A > B)  ? OW'(CMP_GT_RES) : '0;
            ALU_LT:   res_c = (A < B)  ? OW'(CMP_LT_RES) : '0;
            ALU_SHR:  begin lg_c = A >> 1; res_c = OW'(lg_c); end
            ALU_SHL:  res_c = OW'({A, 1'b0});
            default:  err_c = 1'b1;
          endcase
        end
      end
      ST_DIV: begin
`ifdef ALU_DIV_EN
        if (div_done_c) begin
          load_c    = 1'b1;
          res_c     = OW'({div_rem_c, div_quo_c});
          state_nxt = ST_IDLE;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; flags change only alongside a new result
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= ST_IDLE;
      ALU_OUT   <= '0;
      OUT_VALID <= 1'b0;
      CARRY     <= 1'b0;
      ZERO      <= 1'b0;
      ERR       <= 1'b0;
`ifdef ALU_DIV_EN
      BUSY      <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      OUT_VALID <= load_c;
`ifdef ALU_DIV_EN
      BUSY      <= (state_nxt == ST_DIV);
`endif
      if (load_c) begin
        ALU_OUT <= res_c;
        CARRY   <= carry_c;
        ZERO    <= (res_c == '0);
        ERR     <= err_c;
      end
    end
  end

`ifndef ALU_DIV_EN
  assign BUSY = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_pipe.sv
module tb_alu_seq_pipe;
  import alu_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned OW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          en;
  logic [3:0]    fun;
  logic [OW-1:0] alu_out;
  logic          out_valid;
  logic          busy;
  logic          carry;
  logic          zero;
  logic          err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]    fun;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [OW-1:0] out;
    logic          c;
    logic          z;
    logic          e;
  } vec_t;

  vec_t tbl[$];

  alu_seq_pipe #(
    .OPER_WIDTH (W),
    .OUT_WIDTH  (OW)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .A         (a),
    .B         (b),
    .EN        (en),
    .ALU_FUN   (fun),
    .ALU_OUT   (alu_out),
    .OUT_VALID (out_valid),
    .BUSY      (busy),
    .CARRY     (carry),
    .ZERO      (zero),
    .ERR       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [3:0] f, input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic [OW-1:0] o, input logic c, input logic z, input logic e);
    vec_t v;
    v.fun = f; v.a = va; v.b = vb; v.out = o; v.c = c; v.z = z; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation and check the single-cycle result after the edge
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    en = 1'b1; fun = v.fun; a = v.a; b = v.b;
    @(posedge clk); #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".out"},   32'(alu_out),   32'(v.out));
    chk({tag, ".carry"}, 32'(carry),     32'(v.c));
    chk({tag, ".zero"},  32'(zero),      32'(v.z));
    chk({tag, ".err"},   32'(err),       32'(v.e));
    chk({tag, ".busy"},  32'(busy),      32'd0);
  endtask

`ifdef ALU_DIV_EN
  // Divide, with an ADD(1,1) held on EN throughout; the ADD must land one cycle after the quotient
  task automatic div_seq(input logic [W-1:0] da, input logic [W-1:0] db, input logic [OW-1:0] exp,
                         input string tag);
    int edges;
    int busy_cnt;
    bit got;
    @(negedge clk);
    en = 1'b1; fun = ALU_DIV; a = da; b = db;
    @(posedge clk); #1;
    chk({tag, ".busy0"},  32'(busy),      32'd1);
    chk({tag, ".valid0"}, 32'(out_valid), 32'd0);
    busy_cnt = busy ? 1 : 0;
    edges = 0;
    got = 1'b0;
    @(negedge clk);
    fun = ALU_ADD; a = 8'd1; b = 8'd1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      edges++;
      if (out_valid) got = 1'b1;
      else if (busy) busy_cnt++;
    end
    chk({tag, ".latency"},  32'(edges),    32'(W));
    chk({tag, ".busy_cyc"}, 32'(busy_cnt), 32'(W));
    chk({tag, ".out"},      32'(alu_out),  32'(exp));
    chk({tag, ".carry"},    32'(carry),    32'd0);
    chk({tag, ".zero"},     32'(zero),     32'(exp == '0));
    chk({tag, ".err"},      32'(err),      32'd0);
    chk({tag, ".busy_end"}, 32'(busy),     32'd0);
    @(posedge clk); #1;
    chk({tag, ".next_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".next_out"},   32'(alu_out),   32'h0002);
    @(negedge clk);
    en = 1'b0;
  endtask
`endif

  initial begin
    int valid_seen;
    rst = 1'b0; en = 1'b0; fun = '0; a = '0; b = '0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out",   32'(alu_out),   32'd0);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.busy",  32'(busy),      32'd0);
    chk("rst.carry", 32'(carry),     32'd0);
    chk("rst.zero",  32'(zero),      32'd0);
    chk("rst.err",   32'(err),       32'd0);
    @(negedge clk);
    rst = 1'b1;

    tbl.push_back(mk(ALU_ADD,  8'hFF, 8'h01, 16'h0100, 1, 0, 0));
    tbl.push_back(mk(ALU_SUB,  8'd5,  8'd7,  16'hFFFE, 1, 0, 0));
    tbl.push_back(mk(ALU_XOR,  8'h3C, 8'h3C, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(ALU_ADD,  8'h12, 8'h34, 16'h0046, 0, 0, 0));
    tbl.push_back(mk(ALU_SUB,  8'd7,  8'd5,  16'h0002, 0, 0, 0));
    tbl.push_back(mk(ALU_SUB,  8'd0,  8'd0,  16'h0000, 0, 1, 0));
    tbl.push_back(mk(ALU_MUL,  8'hFF, 8'hFF, 16'hFE01, 0, 0, 0));
    tbl.push_back(mk(ALU_MUL,  8'h12, 8'h10, 16'h0120, 0, 0, 0));
    tbl.push_back(mk(ALU_AND,  8'hF0, 8'h3C, 16'h0030, 0, 0, 0));
    tbl.push_back(mk(ALU_OR,   8'hF0, 8'h0F, 16'h00FF, 0, 0, 0));
    tbl.push_back(mk(ALU_NAND, 8'hF0, 8'h3C, 16'h00CF, 0, 0, 0));
    tbl.push_back(mk(ALU_NOR,  8'hF0, 8'h0C, 16'h0003, 0, 0, 0));
    tbl.push_back(mk(ALU_XNOR, 8'hAA, 8'h0F, 16'h005A, 0, 0, 0));
    tbl.push_back(mk(ALU_EQ,   8'h42, 8'h42, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(ALU_EQ,   8'h01, 8'h02, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(ALU_GT,   8'd9,  8'd3,  16'h0002, 0, 0, 0));
    tbl.push_back(mk(ALU_GT,   8'd3,  8'd9,  16'h0000, 0, 1, 0));
    tbl.push_back(mk(ALU_LT,   8'd3,  8'd9,  16'h0003, 0, 0, 0));
    tbl.push_back(mk(ALU_LT,   8'd9,  8'd9,  16'h0000, 0, 1, 0));
    tbl.push_back(mk(ALU_SHR,  8'h81, 8'h00, 16'h0040, 0, 0, 0));
    tbl.push_back(mk(ALU_SHL,  8'h81, 8'h00, 16'h0102, 0, 0, 0));
    tbl.push_back(mk(ALU_SHL,  8'h00, 8'h00, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(ALU_ILL,  8'h12, 8'h34, 16'h0000, 0, 1, 1));
`ifdef ALU_DIV_EN
    tbl.push_back(mk(ALU_DIV,  8'd9,  8'd0,  16'h09FF, 0, 0, 1));
`else
    tbl.push_back(mk(ALU_DIV,  8'd9,  8'd0,  16'h0000, 0, 1, 1));
    tbl.push_back(mk(ALU_DIV,  8'd200, 8'd7, 16'h0000, 0, 1, 1));
`endif
    tbl.push_back(mk(ALU_ADD,  8'h80, 8'h80, 16'h0100, 1, 0, 0));

    // Back-to-back issue: EN stays high across the whole table
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    chk("hold.valid", 32'(out_valid), 32'd0);
    chk("hold.out",   32'(alu_out),   32'h0100);
    chk("hold.carry", 32'(carry),     32'd1);

`ifdef ALU_DIV_EN
    div_seq(8'd200, 8'd7, 16'h041C, "div200_7");
    div_seq(8'd255, 8'd1, 16'h00FF, "div255_1");
    div_seq(8'd5,   8'd9, 16'h0500, "div5_9");
    div_seq(8'd0,   8'd3, 16'h0000, "div0_3");

    // Reset during the 4th DIV cycle aborts the division
    apply(mk(ALU_ADD, 8'hFF, 8'h01, 16'h0100, 1, 0, 0), "pre_abort");
    @(negedge clk);
    en = 1'b1; fun = ALU_DIV; a = 8'd200; b = 8'd7;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort.busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort.out",   32'(alu_out),   32'd0);
    chk("abort.valid", 32'(out_valid), 32'd0);
    chk("abort.busy",  32'(busy),      32'd0);
    chk("abort.carry", 32'(carry),     32'd0);
    chk("abort.zero",  32'(zero),      32'd0);
    chk("abort.err",   32'(err),       32'd0);
    @(negedge clk);
    rst = 1'b1;
    valid_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) valid_seen++;
    end
    chk("abort.no_valid", 32'(valid_seen), 32'd0);
`endif

    apply(mk(ALU_MUL, 8'hFF, 8'hFF, 16'hFE01, 0, 0, 0), "mul_after");
    @(negedge clk);
    en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
